// File: rtl/fpio_fifo_out_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fpio_fifo_arb_pkg
// Shared types and helpers for the fpio FIFO output arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GRANT)
//   pick_t      : result of a rotating-priority pick (found flag + index)
//   id_width    : grant index width for a given requester count (min 1)
//   cnt_width   : burst counter width able to hold 0..max_burst
//   rr_pick     : first set request at or after ptr, wrapping modulo n
// ---------------------------------------------------------------------------
package fpio_fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Upper bound on requesters handled by rr_pick; the index field is sized to it.
  localparam int MAX_REQ = 32;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } pick_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int max_burst);
    return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
  endfunction

  // Scan n positions starting at ptr; the first set bit wins.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
    pick_t res;
    int    idx;
    res = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = ptr + k;
      if (idx >= n) begin
        idx = idx - n;
      end else begin
        idx = idx;
      end
      if ((k < n) && !res.found && req[idx[4:0]]) begin
        res.found = 1'b1;
        res.idx   = idx[4:0];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fpio_fifo_out_arbiter_rr.sv
// ---------------------------------------------------------------------------
// fpio_rr_arbiter
// Combinational rotating-priority picker.
//   req     : request vector, one bit per requester
//   ptr     : index holding highest priority this round
//   gnt_id  : selected requester (valid only when gnt_any)
//   gnt_any : at least one request present
// ---------------------------------------------------------------------------
module fpio_rr_arbiter
  import fpio_fifo_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_any
);

  logic [MAX_REQ-1:0] req_ext_s;
  pick_t              pick_s;

  // Widen the request vector to the helper's fixed width and pick.
  always_comb begin
    req_ext_s        = '0;
    req_ext_s[N-1:0] = req;
    pick_s           = rr_pick(req_ext_s, int'(ptr), N);
    gnt_id           = ID_W'(pick_s.idx);
    gnt_any          = pick_s.found;
  end

endmodule

// File: rtl/fpio_fifo_out_arbiter.sv
// ---------------------------------------------------------------------------
// fpio_fifo_out_arbiter
// Shares one downstream FIFO write port between N_REQ FIFO-read-style
// requesters. Packets are granted round-robin; a grant is held until the
// packet's last beat or until MAX_BURST beats have been moved.
//   clk, rstn     : clock, asynchronous active-low reset
//   en            : gates new grants only (a running packet always completes)
//   req_valid/dat/last, req_rd : requester side (pop on req_rd)
//   out_dat, out_wr, out_full  : downstream FIFO write side
//   grant_valid, grant_id, burst_cnt : current ownership status
// ---------------------------------------------------------------------------
module fpio_fifo_out_arbiter
  import fpio_fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  parameter int ID_W       = id_width(N_REQ),
  localparam int CNT_W     = cnt_width(MAX_BURST)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        en,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_dat,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_rd,
  output logic [DATA_WIDTH-1:0]       out_dat,
  output logic                        out_wr,
  input  logic                        out_full,
  output logic                        grant_valid,
  output logic [ID_W-1:0]             grant_id,
  output logic [CNT_W-1:0]            burst_cnt
);

  arb_state_e       state_r,     state_s;
  logic [ID_W-1:0]  grant_id_r,  grant_id_s;
  logic [ID_W-1:0]  rr_ptr_r,    rr_ptr_s;
  logic [CNT_W-1:0] burst_cnt_r, burst_cnt_s;
  logic [ID_W-1:0]  pick_id_s;
  logic             pick_any_s;
  logic             xfer_s;
  logic             release_s;

  fpio_rr_arbiter #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_r),
    .gnt_id  (pick_id_s),
    .gnt_any (pick_any_s)
  );

  // A beat moves only from the owner, and only when the FIFO has room.
  // The grant ends on the owner's last beat or on the burst-limit beat.
  always_comb begin
    xfer_s    = (state_r == GRANT) & req_valid[grant_id_r] & ~out_full;
    release_s = xfer_s & (req_last[grant_id_r] | (burst_cnt_r == CNT_W'(MAX_BURST - 1)));
  end

  // Next-state logic for the FSM, grant owner, round-robin pointer and burst counter.
  always_comb begin
    state_s     = state_r;
    grant_id_s  = grant_id_r;
    rr_ptr_s    = rr_ptr_r;
    burst_cnt_s = burst_cnt_r;
    case (state_r)
      IDLE: begin
        if (en && pick_any_s) begin
          state_s     = GRANT;
          grant_id_s  = pick_id_s;
          burst_cnt_s = '0;
          if (pick_id_s == ID_W'(N_REQ - 1)) begin
            rr_ptr_s = '0;
          end else begin
            rr_ptr_s = pick_id_s + ID_W'(1);
          end
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        // A stalled or idle owner keeps the port: no timeout by design.
        if (release_s) begin
          state_s     = IDLE;
          burst_cnt_s = '0;
        end else if (xfer_s) begin
          burst_cnt_s = burst_cnt_r + CNT_W'(1);
        end else begin
          burst_cnt_s = burst_cnt_r;
        end
      end
      default: begin
        state_s     = IDLE;
        burst_cnt_s = '0;
      end
    endcase
  end

  // State registers; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      grant_id_r  <= '0;
      rr_ptr_r    <= '0;
      burst_cnt_r <= '0;
    end else begin
      state_r     <= state_s;
      grant_id_r  <= grant_id_s;
      rr_ptr_r    <= rr_ptr_s;
      burst_cnt_r <= burst_cnt_s;
    end
  end

  // Datapath and strobes toward requesters and the downstream FIFO.
  always_comb begin
    req_rd = '0;
    if (xfer_s) begin
      req_rd[grant_id_r] = 1'b1;
    end else begin
      req_rd = '0;
    end
    if (state_r == GRANT) begin
      out_dat = req_dat[int'(grant_id_r)*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      out_dat = '0;
    end
  end

  assign out_wr      = xfer_s;
  assign grant_valid = (state_r == GRANT);
  assign grant_id    = grant_id_r;
  assign burst_cnt   = burst_cnt_r;

endmodule

// File: tb/tb_fpio_fifo_out_arbiter.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for fpio_fifo_out_arbiter (N_REQ=4,
// DATA_WIDTH=8, MAX_BURST=16). Each requester is a simple beat source:
// beat p of requester i carries i*64+p, packets are plen[i] beats long and
// the source pops when req_rd is seen at a clock edge. Inputs change on
// the falling edge; outputs are checked 1 time unit later.
// ---------------------------------------------------------------------------
module tb_fpio_fifo_out_arbiter;

  logic        clk;
  logic        rstn;
  logic        en;
  logic [3:0]  req_valid;
  logic [31:0] req_dat;
  logic [3:0]  req_last;
  logic [3:0]  req_rd;
  logic [7:0]  out_dat;
  logic        out_wr;
  logic        out_full;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [4:0]  burst_cnt;

  int pos   [4];
  int total [4];
  int plen  [4];
  bit hold  [4];

  int tests_run;
  int tests_failed;

  fpio_fifo_out_arbiter #(
    .N_REQ      (4),
    .DATA_WIDTH (8),
    .MAX_BURST  (16)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .en          (en),
    .req_valid   (req_valid),
    .req_dat     (req_dat),
    .req_last    (req_last),
    .req_rd      (req_rd),
    .out_dat     (out_dat),
    .out_wr      (out_wr),
    .out_full    (out_full),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .burst_cnt   (burst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] beat(input int i, input int p);
    logic [7:0] r;
    r = 8'(i * 64 + p);
    return r;
  endfunction

  // Present each source's current beat on the requester inputs.
  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      logic v;
      v = (pos[i] < total[i]) && !hold[i];
      req_valid[i]      = v;
      req_dat[i*8 +: 8] = v ? beat(i, pos[i]) : 8'h00;
      req_last[i]       = v && ((pos[i] % plen[i]) == (plen[i] - 1));
    end
  endtask

  task automatic settle();
    drive();
    #1;
  endtask

  // Pass one clock edge; sources pop on the strobe seen before the edge.
  task automatic advance();
    logic [3:0] rd;
    rd = req_rd;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (rd[i]) pos[i] = pos[i] + 1;
    end
    @(negedge clk);
  endtask

  task automatic clear_sources();
    for (int i = 0; i < 4; i++) begin
      pos[i] = 0; total[i] = 0; plen[i] = 1; hold[i] = 1'b0;
    end
  endtask

  task automatic reset_all();
    rstn = 1'b0; en = 1'b0; out_full = 1'b0;
    clear_sources();
    drive();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1; en = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b1; out_full = 1'b0;
    clear_sources();
    for (int i = 0; i < 4; i++) total[i] = 4;
    drive();
    @(negedge clk);
    #1;
    tests_run++;
    if ({grant_valid, out_wr, req_rd, grant_id, burst_cnt, out_dat} !== 20'h0) begin
      $display("FAIL reset_state: got %h want 00000", {grant_valid, out_wr, req_rd, grant_id, burst_cnt, out_dat});
      tests_failed++;
    end
    reset_all();
  endtask

  task automatic test_single();
    logic [18:0] st, ex;
    reset_all();
    total[0] = 3; plen[0] = 3;
    for (int c = 0; c < 5; c++) begin
      settle();
      st = {grant_valid, out_wr, req_rd, out_dat, burst_cnt};
      if (c >= 1 && c <= 3) ex = {1'b1, 1'b1, 4'b0001, beat(0, c - 1), 5'(c - 1)};
      else                  ex = {1'b0, 1'b0, 4'b0000, 8'h00, 5'd0};
      tests_run++;
      if (st !== ex) begin
        $display("FAIL single_c%0d: got %h want %h", c, st, ex);
        tests_failed++;
      end
      advance();
    end
  endtask

  task automatic test_round_robin();
    logic [18:0] st, ex;
    int id;
    reset_all();
    for (int i = 0; i < 4; i++) begin total[i] = 2; plen[i] = 1; end
    for (int c = 0; c < 10; c++) begin
      settle();
      st = {grant_valid, out_wr, req_rd, out_dat, burst_cnt};
      id = ((c - 1) / 2) % 4;
      if (c % 2 == 1) ex = {1'b1, 1'b1, 4'(1 << id), beat(id, (c == 9) ? 1 : 0), 5'd0};
      else            ex = {1'b0, 1'b0, 4'b0000, 8'h00, 5'd0};
      tests_run++;
      if (st !== ex) begin
        $display("FAIL rr_c%0d: got %h want %h", c, st, ex);
        tests_failed++;
      end
      if (c % 2 == 1) begin
        tests_run++;
        if (grant_id !== 2'(id)) begin
          $display("FAIL rr_id_c%0d: got %0d want %0d", c, grant_id, id);
          tests_failed++;
        end
      end
      advance();
    end
  endtask

  task automatic test_burst_limit();
    logic [18:0] st, ex;
    reset_all();
    total[2] = 40; plen[2] = 40;
    total[3] = 2;  plen[3] = 1;
    for (int c = 0; c < 21; c++) begin
      settle();
      st = {grant_valid, out_wr, req_rd, out_dat, burst_cnt};
      if (c >= 1 && c <= 16) ex = {1'b1, 1'b1, 4'b0100, beat(2, c - 1), 5'(c - 1)};
      else if (c == 18)      ex = {1'b1, 1'b1, 4'b1000, beat(3, 0), 5'd0};
      else if (c == 20)      ex = {1'b1, 1'b1, 4'b0100, beat(2, 16), 5'd0};
      else                   ex = {1'b0, 1'b0, 4'b0000, 8'h00, 5'd0};
      tests_run++;
      if (st !== ex) begin
        $display("FAIL burst_c%0d: got %h want %h", c, st, ex);
        tests_failed++;
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    logic [18:0] st, ex;
    reset_all();
    total[0] = 5; plen[0] = 5;
    for (int c = 0; c < 10; c++) begin
      out_full = (c >= 2 && c <= 4);
      settle();
      st = {grant_valid, out_wr, req_rd, out_dat, burst_cnt};
      if (c == 1)                ex = {1'b1, 1'b1, 4'b0001, beat(0, 0), 5'd0};
      else if (c >= 2 && c <= 4) ex = {1'b1, 1'b0, 4'b0000, beat(0, 1), 5'd1};
      else if (c >= 5 && c <= 8) ex = {1'b1, 1'b1, 4'b0001, beat(0, c - 4), 5'(c - 4)};
      else                       ex = {1'b0, 1'b0, 4'b0000, 8'h00, 5'd0};
      tests_run++;
      if (st !== ex) begin
        $display("FAIL bp_c%0d: got %h want %h", c, st, ex);
        tests_failed++;
      end
      advance();
    end
    out_full = 1'b0;
  endtask

  task automatic test_enable_lock();
    logic [18:0] st, ex;
    // en dropped while requester 1 owns the port
    reset_all();
    total[1] = 3; plen[1] = 3;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) begin en = 1'b0; total[0] = 1; plen[0] = 1; end
      if (c == 6) en = 1'b1;
      settle();
      st = {grant_valid, out_wr, req_rd, out_dat, burst_cnt};
      if (c >= 1 && c <= 3) ex = {1'b1, 1'b1, 4'b0010, beat(1, c - 1), 5'(c - 1)};
      else if (c == 7)      ex = {1'b1, 1'b1, 4'b0001, beat(0, 0), 5'd0};
      else                  ex = {1'b0, 1'b0, 4'b0000, 8'h00, 5'd0};
      tests_run++;
      if (st !== ex) begin
        $display("FAIL en_c%0d: got %h want %h", c, st, ex);
        tests_failed++;
      end
      advance();
    end
    // owner 2 goes quiet mid-packet while everyone else requests
    reset_all();
    total[2] = 4; plen[2] = 4;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) begin hold[2] = 1'b1; total[0] = 1; total[1] = 1; total[3] = 1; end
      if (c == 7) hold[2] = 1'b0;
      settle();
      st = {grant_valid, out_wr, req_rd, out_dat, burst_cnt};
      if (c == 1)                ex = {1'b1, 1'b1, 4'b0100, beat(2, 0), 5'd0};
      else if (c >= 2 && c <= 6) ex = {1'b1, 1'b0, 4'b0000, 8'h00, 5'd1};
      else if (c >= 7 && c <= 9) ex = {1'b1, 1'b1, 4'b0100, beat(2, c - 6), 5'(c - 6)};
      else if (c == 11)          ex = {1'b1, 1'b1, 4'b1000, beat(3, 0), 5'd0};
      else                       ex = {1'b0, 1'b0, 4'b0000, 8'h00, 5'd0};
      tests_run++;
      if (st !== ex) begin
        $display("FAIL lock_c%0d: got %h want %h", c, st, ex);
        tests_failed++;
      end
      if (c >= 1 && c <= 9) begin
        tests_run++;
        if (grant_id !== 2'd2) begin
          $display("FAIL lock_id_c%0d: got %0d want 2", c, grant_id);
          tests_failed++;
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [18:0] st, ex;
    reset_all();
    total[1] = 4; plen[1] = 4;
    settle(); advance();
    settle(); advance();
    settle();
    tests_run++;
    if ({out_wr, req_rd, out_dat} !== {1'b1, 4'b0010, beat(1, 1)}) begin
      $display("FAIL rstmid_beat2: got %h want %h", {out_wr, req_rd, out_dat}, {1'b1, 4'b0010, beat(1, 1)});
      tests_failed++;
    end
    rstn = 1'b0;
    #1;
    tests_run++;
    if ({grant_valid, out_wr, req_rd, grant_id, burst_cnt} !== 12'h0) begin
      $display("FAIL rstmid_async: got %h want 000", {grant_valid, out_wr, req_rd, grant_id, burst_cnt});
      tests_failed++;
    end
    @(negedge clk);
    clear_sources();
    for (int i = 0; i < 4; i++) total[i] = 1;
    rstn = 1'b1;
    for (int c = 0; c < 2; c++) begin
      settle();
      st = {grant_valid, out_wr, req_rd, out_dat, burst_cnt};
      if (c == 1) ex = {1'b1, 1'b1, 4'b0001, beat(0, 0), 5'd0};
      else        ex = {1'b0, 1'b0, 4'b0000, 8'h00, 5'd0};
      tests_run++;
      if (st !== ex) begin
        $display("FAIL rstmid_c%0d: got %h want %h", c, st, ex);
        tests_failed++;
      end
      advance();
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rstn = 1'b0; en = 1'b0; out_full = 1'b0;
    req_valid = '0; req_dat = '0; req_last = '0;
    clear_sources();
    test_reset();
    test_single();
    test_round_robin();
    test_burst_limit();
    test_backpressure();
    test_enable_lock();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fpio_fifo_out_arbiter.md
Name: fpio_fifo_out_arbiter

Overview:
- Shares one fpio FIFO write port (fifo_in side) between N_REQ requesters. Each requester presents FIFO-read-style data.
- Packets are granted round-robin. A grant is held until the packet's last beat or until the MAX_BURST beat limit.
- Sits between multiple fpio_fifo_out_client producers and a single downstream FIFO. It sequences which producer drains into the FIFO.

Parameters:
- N_REQ, 4, number of requesters (>=2)
- DATA_WIDTH, 8, data bits per beat
- MAX_BURST, 16, maximum beats per grant before forced release (>=1)
- ID_W, $clog2(N_REQ), width of grant_id (derived; minimum 1)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- en  in  1  arbitration enable; 0 blocks new grants only
- req_valid  in  N_REQ  requester i has a beat available
- req_dat  in  N_REQ*DATA_WIDTH  requester data; slice i = [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  N_REQ  current beat of requester i ends its packet
- req_rd  out  N_REQ  pop strobe to requester i (beat consumed this cycle)
- out_dat  out  DATA_WIDTH  data to downstream FIFO
- out_wr  out  1  write strobe to downstream FIFO
- out_full  in  1  downstream FIFO full
- grant_valid  out  1  a requester currently owns the port
- grant_id  out  ID_W  index of the owning requester
- burst_cnt  out  $clog2(MAX_BURST+1)  beats transferred in the current grant

Behaviour:
- Interface decision: one clock `clk`; reset `rstn` is asynchronous and active-low.
- States: IDLE, GRANT. Registered: state, grant_id, rr_ptr, burst_cnt.
- Reset values: state=IDLE, grant_valid=0, grant_id=0, rr_ptr=0, burst_cnt=0. out_wr=0 and req_rd=0 during reset.
- IDLE:
  - If en=1 and any req_valid, pick the first requesting index at or after rr_ptr, wrapping modulo N_REQ.
  - Next cycle: state=GRANT, grant_id=pick, rr_ptr=(pick+1) mod N_REQ, burst_cnt=0.
  - Arbitration latency is 1 cycle.
- GRANT:
  - xfer = req_valid[grant_id] & ~out_full. This is combinational.
  - out_wr = xfer. req_rd = one-hot(grant_id) & xfer.
  - out_dat = req_dat slice of grant_id whenever grant_valid; 0 otherwise.
  - On xfer, burst_cnt increments.
  - Release (next state IDLE, burst_cnt cleared) occurs when xfer & (req_last[grant_id] | burst_cnt==MAX_BURST-1).
- Packet lock: if the owner drops req_valid mid-packet, the grant is held indefinitely. There is no timeout, and no other requester is served.
- Inter-grant gap: exactly 1 IDLE cycle after each release. No transfer occurs in IDLE.
- out_full=1: no transfer. State and burst_cnt are held. Data remains presented.
- en=0 in GRANT: the current packet continues to completion. en=0 only gates IDLE->GRANT.
- Requests from non-owners are ignored while GRANT. No starvation: after any grant to i, every other valid requester is served before i is served again.
- req_last on a non-transfer cycle has no effect.
- Asynchronous reset mid-packet: immediate return to reset values. The partial packet is abandoned, and requesters must handle it.
- grant_valid = (state==GRANT).

Decomposition:
- Package fpio_fifo_arb_pkg:
  - state enum {IDLE, GRANT}
  - function rr_pick(req, ptr, n) returning index and found flag
  - localparam helpers for ID_W and burst counter width
- Sub-module fpio_rr_arbiter: combinational rotating-priority picker.
  - Parameter N.
  - Inputs: req[N], ptr[ID_W].
  - Outputs: gnt_id, gnt_any.

Test Plan:
- Single requester: req_valid=0001, 3-beat packet (last on beat 3), out_full=0. Grant 1 cycle after request; out_wr high 3 consecutive cycles with data A0,A1,A2; req_rd=0001 each; then IDLE.
- Round-robin: all 4 requesters have 1-beat packets continuously from reset. Grant order 0,1,2,3,0; each grant followed by a 1-cycle gap.
- Burst limit: MAX_BURST=16, requester 2 sends a 40-beat packet with requester 3 also valid. Sequence is 16 beats from 2, release, 3 served, then 2 resumes. burst_cnt reaches 15 before release.
- Backpressure: out_full asserted for cycles 2-4 of a 5-beat packet. out_wr=0 and req_rd=0 on those cycles; burst_cnt held; all 5 beats delivered in order.
- Enable and lock: en dropped mid-packet. The packet completes and no new grant issues until en=1. Owner drops valid for 5 cycles mid-packet while others request: grant_id unchanged throughout.
- Reset mid-packet: assert rstn=0 on beat 2 of 4. grant_valid=0, out_wr=0, rr_ptr=0 immediately. After release, requester 0 wins first.
